// File: rtl/fp_to_int.sv
// fp_to_int: IEEE-754 single precision to signed 32-bit integer conversion.
// Round-to-nearest-even. The mantissa is aligned by a serial shifter that
// moves up to SHIFT_STEP bits per cycle, under valid/ready handshakes on
// both sides, with one conversion in flight at a time.
module fp_to_int #(
   parameter int SHIFT_STEP = 1   // 1, 2 or 4 bits per ALIGN cycle
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] src,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out,
   output logic        inexact,
   output logic        invalid
);

   localparam logic [31:0] MAX_POS = 32'h7FFF_FFFF;
   localparam logic [31:0] MIN_NEG = 32'h8000_0000;

   typedef enum logic [1:0] {IDLE, ALIGN, ROUND, DONE} state_t;

   state_t      state;
   logic        sign;
   logic        left;          // alignment direction of the captured operand
   logic [31:0] mag;           // working magnitude
   logic        g, r, s;       // guard, round and sticky bits
   logic [4:0]  cnt;           // remaining shift count
   logic        special;       // result fixed at capture, no rounding
   logic [31:0] spec_out;
   logic        spec_inexact;
   logic        spec_invalid;

   logic [7:0]  exp_f;
   logic [22:0] frac;
   logic [7:0]  rdist;
   assign exp_f = src[30:23];
   assign frac  = src[22:0];
   // Right-shift distance 150-exp is 23-e, valid whenever exp < 150.
   assign rdist = 8'd150 - exp_f;

   logic        dec_special, dec_inexact, dec_invalid, dec_left;
   logic [31:0] dec_out;
   logic [4:0]  dec_cnt;

   // Decode the incoming operand: specials, shift direction and count.
   always_comb begin
      // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
      dec_special = 1'b0;
      dec_inexact = 1'b0;
      dec_invalid = 1'b0;
      dec_left    = 1'b0;
      dec_out     = '0;
      dec_cnt     = '0;
      if (exp_f == 8'hFF) begin
         // NaN and +inf saturate high, -inf saturates low.
         dec_special = 1'b1;
         dec_invalid = 1'b1;
         dec_out     = (frac != '0 || !src[31]) ? MAX_POS : MIN_NEG;
      end else if (exp_f == 8'h00) begin
         // Zero or denormal: always 0, sign dropped.
         dec_special = 1'b1;
         dec_inexact = (frac != '0);
      end else if (exp_f >= 8'd158) begin
         // |x| >= 2^31; only exactly -2^31 is representable.
         dec_special = 1'b1;
         dec_out     = src[31] ? MIN_NEG : MAX_POS;
         dec_invalid = (src != 32'hCF00_0000);
      end else if (exp_f >= 8'd150) begin
         // exp is 150..157 here, whose low five bits run 22..29 without wrap.
         dec_left = 1'b1;
         dec_cnt  = exp_f[4:0] - 5'd22;
      end else begin
         dec_cnt = (rdist > 8'd25) ? 5'd25 : rdist[4:0];
      end
   end

   logic [31:0] a_mag;
   logic        a_g, a_r, a_s;
   logic [4:0]  a_cnt;

   // One ALIGN step: up to SHIFT_STEP single-bit shifts, stopping at zero.
   always_comb begin
      a_mag = mag;
      a_g   = g;
      a_r   = r;
      a_s   = s;
      a_cnt = cnt;
      // NOTE: blocking assignments here chain the bit shifts within one cycle.
      for (int i = 0; i < SHIFT_STEP; i++) begin
         if (a_cnt != 5'd0) begin
            if (left) begin
               a_mag = a_mag << 1;
            end else begin
               a_s   = a_s | a_r;
               a_r   = a_g;
               a_g   = a_mag[0];
               a_mag = a_mag >> 1;
            end
            a_cnt = a_cnt - 5'd1;
         end
      end
   end

   logic        inc;
   logic [32:0] rmag;
   logic [31:0] rnd_out;
   logic        rnd_invalid;

   // Round to nearest even, apply the sign and saturate on overflow.
   always_comb begin
      inc         = g & (r | s | mag[0]);
      rmag        = {1'b0, mag} + {32'd0, inc};
      rnd_out     = rmag[31:0];
      rnd_invalid = 1'b0;
      if (sign) begin
         if (rmag > 33'h0_8000_0000) begin
            rnd_out     = MIN_NEG;
            rnd_invalid = 1'b1;
         end else begin
            rnd_out = ~rmag[31:0] + 32'd1;
         end
      end else if (rmag > 33'h0_7FFF_FFFF) begin
         rnd_out     = MAX_POS;
         rnd_invalid = 1'b1;
      end
   end

   // Conversion sequencer with registered handshake and result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         in_ready     <= 1'b1;
         out_valid    <= 1'b0;
         out          <= '0;
         inexact      <= 1'b0;
         invalid      <= 1'b0;
         sign         <= 1'b0;
         left         <= 1'b0;
         mag          <= '0;
         g            <= 1'b0;
         r            <= 1'b0;
         s            <= 1'b0;
         cnt          <= '0;
         special      <= 1'b0;
         spec_out     <= '0;
         spec_inexact <= 1'b0;
         spec_invalid <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignments so all update on the same edge.
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  sign         <= src[31];
                  left         <= dec_left;
                  mag          <= {8'd0, 1'b1, frac};
                  g            <= 1'b0;
                  r            <= 1'b0;
                  s            <= 1'b0;
                  cnt          <= dec_cnt;
                  special      <= dec_special;
                  spec_out     <= dec_out;
                  spec_inexact <= dec_inexact;
                  spec_invalid <= dec_invalid;
                  in_ready     <= 1'b0;
                  state        <= ALIGN;
               end
            end
            ALIGN: begin
               mag <= a_mag;
               g   <= a_g;
               r   <= a_r;
               s   <= a_s;
               cnt <= a_cnt;
               if (a_cnt == 5'd0) state <= ROUND;
            end
            ROUND: begin
               if (special) begin
                  out     <= spec_out;
                  inexact <= spec_inexact;
                  invalid <= spec_invalid;
               end else begin
                  out     <= rnd_out;
                  inexact <= g | r | s;
                  invalid <= rnd_invalid;
               end
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_to_int.sv
// Self-checking bench for fp_to_int: SHIFT_STEP=1 and SHIFT_STEP=4 instances
// compared against an arithmetic reference model of float-to-int rounding.
module tb_fp_to_int;

   typedef struct packed {
      logic [31:0] value;
      logic        inexact;
      logic        invalid;
   } result_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid_a  [2];
   logic        in_ready_a  [2];
   logic [31:0] src_a       [2];
   logic        out_valid_a [2];
   logic        out_ready_a [2];
   logic [31:0] out_a       [2];
   logic        inexact_a   [2];
   logic        invalid_a   [2];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fp_to_int #(.SHIFT_STEP(1)) u_step1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]), .src(src_a[0]),
      .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]), .out(out_a[0]),
      .inexact(inexact_a[0]), .invalid(invalid_a[0])
   );

   fp_to_int #(.SHIFT_STEP(4)) u_step4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]), .src(src_a[1]),
      .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]), .out(out_a[1]),
      .inexact(inexact_a[1]), .invalid(invalid_a[1])
   );

   // Exact value is m * 2^k with m the 24-bit significand; round half to even.
   function automatic result_t model(input logic [31:0] v);
      result_t res;
      int      ex;
      int      k;
      longint  m, q, rem, half, limit;
      res = '0;
      ex  = int'(v[30:23]);
      if (ex == 255) begin
         res.invalid = 1'b1;
         res.value   = (v[22:0] != 0 || !v[31]) ? 32'h7FFF_FFFF : 32'h8000_0000;
         return res;
      end
      if (ex == 0) begin
         res.inexact = (v[22:0] != 0);
         return res;
      end
      m = longint'({1'b1, v[22:0]});
      k = ex - 150;
      if (k >= 0) begin
         q = (k > 39) ? 64'h4000_0000_0000_0000 : (m << k);
      end else if (-k > 40) begin
         q = 0;
         res.inexact = 1'b1;
      end else begin
         q    = m >> (-k);
         rem  = m - (q << (-k));
         half = 64'd1 << (-k - 1);
         res.inexact = (rem != 0);
         if (rem > half || (rem == half && q[0])) q = q + 1;
      end
      limit = v[31] ? 64'h8000_0000 : 64'h7FFF_FFFF;
      if (q > limit) begin
         res.invalid = 1'b1;
         res.value   = v[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
         res.value = v[31] ? 32'(-q) : 32'(q);
      end
      return res;
   endfunction

   // Cycles from the accept edge to out_valid: one per ALIGN step plus ROUND.
   function automatic int exp_lat(input logic [31:0] v, input int step);
      int ex, sh, n;
      ex = int'(v[30:23]);
      if (ex == 255 || ex == 0 || ex >= 158) sh = 0;
      else if (ex >= 150)                    sh = ex - 150;
      else                                   sh = (150 - ex > 25) ? 25 : 150 - ex;
      n = (sh == 0) ? 1 : (sh + step - 1) / step;
      return n + 1;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Present an operand and wait for it to be taken; keep leaves in_valid high.
   task automatic start(input int u, input logic [31:0] v, input bit keep);
      int n = 0;
      @(negedge clk);
      while (!in_ready_a[u] && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_before_accept", {31'd0, in_ready_a[u]}, 32'd1);
      src_a[u]      = v;
      in_valid_a[u] = 1'b1;
      @(posedge clk);
      #1;
      if (!keep) in_valid_a[u] = 1'b0;
   endtask

   // Wait for the result, check it and its latency, hold it, then retire it.
   task automatic finish_conv(input int u, input logic [31:0] v, input int hold);
      result_t m;
      int      cyc = 0;
      bit      busy_ready = 1'b0;
      m = model(v);
      while (!out_valid_a[u] && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
         if (in_ready_a[u]) busy_ready = 1'b1;
      end
      check($sformatf("latency u%0d %h", u, v), cyc, exp_lat(v, (u == 0) ? 1 : 4));
      check($sformatf("out u%0d %h", u, v), out_a[u], m.value);
      check($sformatf("inexact u%0d %h", u, v), {31'd0, inexact_a[u]}, {31'd0, m.inexact});
      check($sformatf("invalid u%0d %h", u, v), {31'd0, invalid_a[u]}, {31'd0, m.invalid});
      check("in_ready_busy", {31'd0, busy_ready}, 32'd0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check("hold_valid", {31'd0, out_valid_a[u]}, 32'd1);
         check("hold_out", out_a[u], m.value);
         check("hold_flags", {30'd0, inexact_a[u], invalid_a[u]}, {30'd0, m.inexact, m.invalid});
         check("hold_in_ready", {31'd0, in_ready_a[u]}, 32'd0);
      end
      @(negedge clk);
      out_ready_a[u] = 1'b1;
      @(posedge clk);
      #1;
      out_ready_a[u] = 1'b0;
      check("release_valid", {31'd0, out_valid_a[u]}, 32'd0);
      check("release_in_ready", {31'd0, in_ready_a[u]}, 32'd1);
   endtask

   logic [31:0] directed [16];
   logic [31:0] rv;

   initial begin
      directed = '{32'h3FC0_0000, 32'h4020_0000, 32'h4060_0000, 32'hC020_0000,
                   32'h3F00_0000, 32'h3F00_0001, 32'h3E80_0000, 32'h8000_0000,
                   32'h4B00_0001, 32'h4EFF_FFFF, 32'h4F00_0000, 32'hCF00_0000,
                   32'h7FC0_0000, 32'hFF80_0000, 32'h0000_0001, 32'h7F80_0000};
      rst_n = 1'b0;
      for (int u = 0; u < 2; u++) begin
         in_valid_a[u]  = 1'b0;
         out_ready_a[u] = 1'b0;
         src_a[u]       = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      check("reset_in_ready", {31'd0, in_ready_a[0]}, 32'd1);
      check("reset_out_valid", {31'd0, out_valid_a[0]}, 32'd0);
      check("reset_out", out_a[0], 32'd0);
      check("reset_flags", {30'd0, inexact_a[0], invalid_a[0]}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed operands on both shifter widths; 1.5 held under backpressure.
      for (int u = 0; u < 2; u++) begin
         for (int i = 0; i < 16; i++) begin
            start(u, directed[i], 1'b0);
            finish_conv(u, directed[i], (i == 0) ? 5 : 0);
         end
      end

      // in_valid held high: the second operand waits for the first to retire.
      start(0, 32'h4020_0000, 1'b1);
      src_a[0] = 32'h4060_0000;
      finish_conv(0, 32'h4020_0000, 2);
      start(0, 32'h4060_0000, 1'b0);
      finish_conv(0, 32'h4060_0000, 0);

      // Reset mid-ALIGN aborts the conversion with no output.
      start(0, 32'h3FC0_0000, 1'b0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", {31'd0, out_valid_a[0]}, 32'd0);
      check("abort_in_ready", {31'd0, in_ready_a[0]}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      start(0, 32'h4060_0000, 1'b0);
      finish_conv(0, 32'h4060_0000, 0);

      // Random operands, exponents concentrated around the interesting range.
      for (int n = 0; n < 60; n++) begin
         rv = $urandom;
         if (n % 4 != 3) rv[30:23] = 8'($urandom_range(100, 165));
         start(n % 2, rv, 1'b0);
         finish_conv(n % 2, rv, $urandom_range(0, 2));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fp_to_int.md
Name: fp_to_int

Overview:
- Converts an IEEE-754 single-precision operand to a signed 32-bit two's-complement integer.
- Rounding is round-to-nearest-even, the same rule the fp adder uses when it packs results. The adder packs toward float; this block unpacks out of it.
- Multi-cycle and iterative: mantissa alignment is done by a serial shifter under valid/ready handshakes on both sides.
- Sits between the FP datapath and integer consumers such as the ALU writeback and address generation.

Parameters:
- SHIFT_STEP, 1, maximum bits shifted per ALIGN cycle. Legal values are 1, 2 and 4. The final step shifts only the remaining count.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  src is valid
- in_ready  output  1  block can accept an operand
- src  input  32  IEEE-754 single operand
- out_valid  output  1  result is valid
- out_ready  input  1  consumer accepts the result
- out  output  32  signed integer result
- inexact  output  1  result differs from the exact value (nonzero G or S bits)
- invalid  output  1  NaN, infinity or out-of-range input; out is saturated

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE; in_ready=1; out_valid=0; out=0; inexact=0; invalid=0.
  - Reset asserted in any state aborts the conversion in flight with no output.
- States: IDLE, ALIGN, ROUND, DONE.
- IDLE:
  - in_ready=1. When in_valid&in_ready at edge T, capture the operand: sign, e=exp-127, and mag={8'd0,1,frac} as a 32-bit working register. Clear G, R and S.
  - Compute the shift count:
    - e>=23: left shift by e-23 (0..7).
    - e<23: right shift by min(23-e,25).
  - Go to ALIGN. in_ready=0 from T+1 until the return to IDLE.
- Special cases (zero shift cycles, pass through ALIGN and ROUND unchanged):
  - exp==255, NaN: out=0x7FFFFFFF, invalid=1.
  - exp==255, +inf: out=0x7FFFFFFF, invalid=1.
  - exp==255, -inf: out=0x80000000, invalid=1.
  - exp==0 (zero or denormal): out=0, invalid=0, inexact=(frac!=0).
  - e>=31: out=0x7FFFFFFF (positive) or 0x80000000 (negative), invalid=1. Exception: src==0xCF000000 gives 0x80000000 with invalid=0.
- ALIGN:
  - Each cycle shifts by min(SHIFT_STEP, remaining).
  - Right shift: bits leave through G, then R; everything below R ORs into S.
  - Left shift fills with zeros.
  - Remaining==0 goes to ROUND. A zero count spends exactly one cycle in ALIGN.
- ROUND:
  - Increment mag if G&(R|S|mag[0]). G is the first dropped bit; R and S together form the sticky.
  - inexact=G|R|S.
  - Negate if sign.
  - If the rounded magnitude exceeds 0x7FFFFFFF (positive) or 0x80000000 (negative): saturate and set invalid=1.
  - Go to DONE.
- DONE:
  - out_valid=1. out, inexact and invalid are stable while out_valid&!out_ready.
  - On out_valid&out_ready, clear out_valid and return to IDLE; in_ready rises the same edge. No overlap, so one conversion is in flight at a time.
- Latency:
  - N = ceil(shift_count/SHIFT_STEP), with N=1 when the count is 0.
  - Accept at edge T gives out_valid high after edge T+N+1, assuming no backpressure.
  - Throughput: one result per N+3 cycles when out_ready=1.
- The sign of zero is dropped: -0.0 gives 0.
- Left shifts never lose bits, since e<=30 keeps magnitude <2^31.

Test Plan:
- Rounding, SHIFT_STEP=1:
  - src=0x3FC00000 (1.5) -> out=0x00000002, inexact=1, invalid=0. out_valid after edge T+24.
  - src=0x40200000 (2.5) -> out=2, inexact=1.
  - src=0x40600000 (3.5) -> out=4.
  - src=0xC0200000 (-2.5) -> out=0xFFFFFFFE.
- Boundary near 0.5:
  - src=0x3F000000 (0.5) -> out=0, inexact=1.
  - src=0x3F000001 -> out=1.
  - src=0x3E800000 (0.25, shift cap 25) -> out=0, inexact=1.
  - src=0x80000000 -> out=0, inexact=0.
- Exact and left-shift paths:
  - src=0x4B000001 -> out=0x00800001, inexact=0, zero-count path, out_valid after T+2.
  - src=0x4EFFFFFF -> out=0x7FFFFF80, exact, 7 left shifts.
- Saturation and specials:
  - src=0x4F000000 -> 0x7FFFFFFF, invalid=1.
  - src=0xCF000000 -> 0x80000000, invalid=0.
  - src=0x7FC00000 -> 0x7FFFFFFF, invalid=1.
  - src=0xFF800000 -> 0x80000000, invalid=1.
  - src=0x00000001 -> 0, inexact=1.
- Handshake:
  - Hold out_ready=0 for 5 cycles in DONE -> out, inexact and invalid stable; in_ready=0 throughout.
  - in_valid held high during a conversion is not accepted until DONE completes.
- Reset and SHIFT_STEP=4:
  - Drop rst_n mid-ALIGN on 1.5 -> out_valid=0 and in_ready=1 immediately; the next operand 0x40600000 converts to 4.
  - Rerun 0x3FC00000 with SHIFT_STEP=4 -> out=2, out_valid after T+7.
